// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the instruction cache.
//   XLEN          - fetch/memory address width
//   ICACHE_LINES  - number of direct-mapped lines (8-byte blocks)
//   BUS_COMMAND   - memory bus command encoding (BUS_NONE / BUS_LOAD)
//   ICACHE_ENTRY  - one line of the tag/data array
//   ICACHE_STATE  - miss-handling FSM states
package icache_pkg;

    localparam int XLEN          = 32;
    localparam int ICACHE_LINES  = 32;
    localparam int ICACHE_IDX_W  = 5;
    localparam int ICACHE_TAG_W  = XLEN - 8;
    localparam int MEM_TAG_W     = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef struct packed {
        logic [63:0]             data;
        logic [ICACHE_TAG_W-1:0] tag;
        logic                    valid;
    } ICACHE_ENTRY;

    typedef enum logic [1:0] {
        IDLE = 2'h0,
        REQ  = 2'h1,
        WAIT = 2'h2
    } ICACHE_STATE;

endpackage

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, 32 lines x 8-byte blocks, with a
// single outstanding miss to memory.
//   clock, reset             - system clock; synchronous active-high reset
//   proc2Icache_addr         - fetch address (always a live request)
//   Icache2proc_data(_valid) - block containing the fetch address on a hit
//   proc2mem_command/addr    - BUS_LOAD of the block-aligned miss address
//   mem2proc_response        - tag granted by memory (0 = rejected, retry)
//   mem2proc_data/tag        - returned block and its tag (tag 0 = idle)
module icache
    import icache_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] proc2Icache_addr,
    output logic [63:0]     Icache2proc_data,
    output logic            Icache2proc_data_valid,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag
);

    ICACHE_ENTRY              lines_q [ICACHE_LINES];
    ICACHE_STATE              state_q, state_d;
    logic [XLEN-1:3]          miss_blk_q, miss_blk_d;
    logic [MEM_TAG_W-1:0]     mem_tag_q, mem_tag_d;

    logic [ICACHE_IDX_W-1:0]  req_idx;
    logic [ICACHE_TAG_W-1:0]  req_tag;
    logic [XLEN-1:3]          req_blk;
    logic [ICACHE_IDX_W-1:0]  fill_idx;
    ICACHE_ENTRY              rd_line;
    logic                     hit;
    logic                     fill;
    logic                     unused_offset;

    assign req_idx  = proc2Icache_addr[7:3];
    assign req_tag  = proc2Icache_addr[XLEN-1:8];
    assign req_blk  = proc2Icache_addr[XLEN-1:3];
    assign fill_idx = miss_blk_q[7:3];
    // Byte offset inside the block does not affect lookup.
    assign unused_offset = ^proc2Icache_addr[2:0];

    assign rd_line = lines_q[req_idx];
    assign hit     = rd_line.valid && (rd_line.tag == req_tag);

    assign Icache2proc_data_valid = hit;
    assign Icache2proc_data       = hit ? rd_line.data : '0;

    always_comb begin
        state_d          = state_q;
        miss_blk_d       = miss_blk_q;
        mem_tag_d        = mem_tag_q;
        fill             = 1'b0;
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;

        case (state_q)
            IDLE: begin
                if (!hit) begin
                    state_d    = REQ;
                    miss_blk_d = req_blk;
                end
            end

            REQ: begin
                proc2mem_command = BUS_LOAD;
                proc2mem_addr    = {miss_blk_q, 3'b000};
                // An accepted request belongs to the address issued this
                // cycle; a fetch redirect only matters while still retrying.
                if (mem2proc_response != '0) begin
                    state_d   = WAIT;
                    mem_tag_d = mem2proc_response;
                end else if (req_blk != miss_blk_q) begin
                    if (hit) begin
                        state_d = IDLE;
                    end else begin
                        miss_blk_d = req_blk;
                    end
                end
            end

            WAIT: begin
                // Fill goes to the latched miss block regardless of where
                // fetch has moved since.
                if ((mem_tag_q != '0) && (mem2proc_tag == mem_tag_q)) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            miss_blk_q <= '0;
            mem_tag_q  <= '0;
            for (int unsigned i = 0; i < ICACHE_LINES; i++) begin
                lines_q[i].valid <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            miss_blk_q <= miss_blk_d;
            mem_tag_q  <= mem_tag_d;
            if (fill) begin
                lines_q[fill_idx].data  <= mem2proc_data;
                lines_q[fill_idx].tag   <= miss_blk_q[XLEN-1:8];
                lines_q[fill_idx].valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: cycle-by-cycle directed scenarios for icache. Each cycle's
// stimulus pushes the expected outputs onto a scoreboard queue; the entry is
// popped and compared against the DUT on the falling edge of that cycle.
module tb_icache;

    localparam logic [1:0] CMD_NONE = 2'h0;
    localparam logic [1:0] CMD_LOAD = 2'h1;

    localparam logic [63:0] D1 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D3 = 64'hAAAA_5555_CAFE_F00D;
    localparam logic [63:0] D4 = 64'h0BAD_0BAD_0BAD_0BAD;
    localparam logic [63:0] DJ = 64'hFFFF_0000_FFFF_0000;

    logic        clock;
    logic        reset;
    logic [31:0] proc2Icache_addr;
    logic [63:0] Icache2proc_data;
    logic        Icache2proc_data_valid;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    typedef struct {
        int          cyc;
        logic        valid;
        logic [63:0] data;
        logic [1:0]  cmd;
        logic [31:0] maddr;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc_n        = 0;

    icache dut (
        .clock                  (clock),
        .reset                  (reset),
        .proc2Icache_addr       (proc2Icache_addr),
        .Icache2proc_data       (Icache2proc_data),
        .Icache2proc_data_valid (Icache2proc_data_valid),
        .proc2mem_command       (proc2mem_command),
        .proc2mem_addr          (proc2mem_addr),
        .mem2proc_response      (mem2proc_response),
        .mem2proc_data          (mem2proc_data),
        .mem2proc_tag           (mem2proc_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare on the
    // falling edge, then advance to just after the next rising edge.
    task automatic cyc(input logic rst, input logic [31:0] addr,
                       input logic [3:0] resp, input logic [3:0] mtag,
                       input logic [63:0] mdata, input logic ev,
                       input logic [63:0] ed, input logic [1:0] ec,
                       input logic [31:0] ea);
        exp_t e;
        exp_t got;
        reset             = rst;
        proc2Icache_addr  = addr;
        mem2proc_response = resp;
        mem2proc_tag      = mtag;
        mem2proc_data     = mdata;
        cyc_n++;
        e.cyc   = cyc_n;
        e.valid = ev;
        e.data  = ev ? ed : 64'h0;
        e.cmd   = ec;
        e.maddr = ea;
        exp_q.push_back(e);
        @(negedge clock);
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL c%0d.scoreboard: got empty queue expected entry", cyc_n);
        end else begin
            got = exp_q.pop_front();
            check_eq($sformatf("c%0d.valid", got.cyc), {63'h0, Icache2proc_data_valid}, {63'h0, got.valid});
            check_eq($sformatf("c%0d.data", got.cyc), Icache2proc_data, got.data);
            check_eq($sformatf("c%0d.cmd", got.cyc), {62'h0, proc2mem_command}, {62'h0, got.cmd});
            check_eq($sformatf("c%0d.maddr", got.cyc), {32'h0, proc2mem_addr}, {32'h0, got.maddr});
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        proc2Icache_addr  = 32'h0;
        mem2proc_response = 4'h0;
        mem2proc_tag      = 4'h0;
        mem2proc_data     = 64'h0;
        @(posedge clock);
        #1;

        // Reset state
        cyc(1, 32'h0000_0000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);

        // Cold miss on 0x1000, grant tag 3, fill, then hit
        cyc(0, 32'h0000_1000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_1000, 3, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_1000);
        cyc(0, 32'h0000_1000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_1000, 0, 3, D1,    0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_1000, 0, 0, 64'h0, 1, D1, CMD_NONE, 32'h0);
        // Same block, different offset
        cyc(0, 32'h0000_1004, 0, 0, 64'h0, 1, D1, CMD_NONE, 32'h0);

        // Conflict miss 0x2000 with three rejections
        cyc(0, 32'h0000_2000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_2000, 0, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_2000);
        cyc(0, 32'h0000_2000, 0, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_2000);
        cyc(0, 32'h0000_2000, 0, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_2000);
        cyc(0, 32'h0000_2000, 5, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_2000);
        cyc(0, 32'h0000_2000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_2000, 0, 5, D2,    0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_2000, 0, 0, 64'h0, 1, D2, CMD_NONE, 32'h0);
        // 0x1000 was evicted
        cyc(0, 32'h0000_1000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        // Redirect to a hitting address while in REQ returns to IDLE
        cyc(0, 32'h0000_2000, 0, 0, 64'h0, 1, D2, CMD_LOAD, 32'h0000_1000);
        cyc(0, 32'h0000_2000, 0, 0, 64'h0, 1, D2, CMD_NONE, 32'h0);

        // Miss 0x3000, fetch moves to 0x4000 during WAIT, stray tag 7
        cyc(0, 32'h0000_3000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_3000, 6, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_3000);
        cyc(0, 32'h0000_4000, 0, 7, DJ,    0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_4000, 0, 6, D3,    0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_4000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_3000, 0, 0, 64'h0, 1, D3, CMD_LOAD, 32'h0000_4000);
        cyc(0, 32'h0000_3000, 0, 0, 64'h0, 1, D3, CMD_NONE, 32'h0);

        // Retarget in REQ from 0x5000 to 0x6000
        cyc(0, 32'h0000_5000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_5000, 0, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_5000);
        cyc(0, 32'h0000_6000, 0, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_5000);
        cyc(0, 32'h0000_6000, 2, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_6000);

        // Reset in WAIT, then late tag 2 must not fill
        cyc(0, 32'h0000_6000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        cyc(1, 32'h0000_6000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_6000, 0, 2, D4,    0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_6000, 0, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_6000);

        // Reset wins over a fill arriving in the same cycle
        cyc(0, 32'h0000_6000, 4, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_6000);
        cyc(1, 32'h0000_6000, 0, 4, D4,    0, 0, CMD_NONE, 32'h0);
        cyc(0, 32'h0000_6000, 0, 0, 64'h0, 0, 0, CMD_NONE, 32'h0);
        // Earlier lines were also invalidated by reset
        cyc(0, 32'h0000_3000, 0, 0, 64'h0, 0, 0, CMD_LOAD, 32'h0000_6000);

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
